// File: rtl/div32_seq.sv
// div32_seq: sequential signed 32-bit non-restoring divider, Z = {rem, quot}.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips CALC and finishes in 2 cycles.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic [2*WIDTH-1:0] Z,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               sx_q, sx_d;
    logic               sy_q, sy_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   abs_x, abs_y;
    logic [WIDTH:0]     p_sh, p_add, p_sub, p_step, p_fix;
    logic [WIDTH-1:0]   quot, rem;

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state, one non-restoring step per CALC cycle, sign fix-up in FIX.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        dz_d    = dz_q;

        abs_x  = X[WIDTH-1] ? -X : X;
        abs_y  = Y[WIDTH-1] ? -Y : Y;
        p_sh   = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
        p_add  = p_sh + {1'b0, b_q};
        p_sub  = p_sh - {1'b0, b_q};
        p_step = p_q[WIDTH] ? p_add : p_sub;
        p_fix  = p_q[WIDTH] ? (p_q + {1'b0, b_q}) : p_q;
        quot   = (sx_q ^ sy_q) ? -a_q : a_q;
        rem    = sx_q ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    x_d     = X;
                    y_d     = Y;
                    sx_d    = X[WIDTH-1];
                    sy_d    = Y[WIDTH-1];
                    a_d     = abs_x;
                    b_d     = abs_y;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (Y == '0) state_d = S_FIX;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                p_d   = p_step;
                a_d   = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                p_d     = p_fix;
                state_d = S_DONE;
                if (y_q == '0) begin
                    z_d  = {x_q, {WIDTH{1'b1}}};
                    dz_d = 1'b1;
                end else begin
                    z_d  = {rem, quot};
                    dz_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status decode from the current state.
    always_comb begin
        busy     = (state_q == S_CALC) || (state_q == S_FIX);
        done     = (state_q == S_DONE);
        Z        = z_q;
        div_zero = dz_q;
    end

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed vectors, expected results queued, monitor compares on done.
// Latency expectations follow DIV_ZERO_FAST_EN for the zero-divisor cases.
module tb_div32_seq;

    typedef struct packed {
        logic [63:0] z;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        clr_n;
    logic        start;
    logic [31:0] X;
    logic [31:0] Y;
    logic [63:0] Z;
    logic        busy;
    logic        done;
    logic        div_zero;

    exp_t sb[$];
    int   errors;
    int   checks;

`ifdef DIV_ZERO_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 33;
`endif

    div32_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .X        (X),
        .Y        (Y),
        .Z        (Z),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (clr_n && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got Z=%h expected no result", Z);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("Z", Z, e.z);
                    chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                end
            end
        end
    end

    // Issue one operation at the current negedge; waits for done.
    task automatic run(input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] ez, input logic edz,
                       input int lat);
        int k;
        exp_t e;
        X = x;
        Y = y;
        start = 1'b1;
        e.z = ez;
        e.dz = edz;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        k = 0;
        while (!done && k < 100) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("latency", 64'(k), 64'(lat));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int k;
        errors = 0;
        checks = 0;
        clr_n = 1'b0;
        start = 1'b0;
        X = '0;
        Y = '0;
        repeat (3) @(negedge clk);
        chk("rst_Z", Z, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, div_zero}, 64'd0);

        clr_n = 1'b1;
        run(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);
        run(32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 33);
        run(32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0, 33);
        run(32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0, 33);
        run(32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33);
        run(32'd7, 32'd100, 64'h00000007_00000000, 1'b0, 33);
        run(32'h80000000, 32'h80000000, 64'h00000000_00000001, 1'b0, 33);
        run(32'h7FFFFFFF, 32'd2, 64'h00000001_3FFFFFFF, 1'b0, 33);
        run(32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, DZ_LAT);
        run(32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1'b1, DZ_LAT);
        run(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 33);

        // Abort an operation with reset mid-CALC.
        X = 32'd100;
        Y = 32'd7;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        clr_n = 1'b0;
        #1;
        chk("abort_Z", Z, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        clr_n = 1'b1;
        run(32'hFFFFFFF7, 32'd2, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 33);

        // Operand changes and a stray start while busy must be ignored.
        @(negedge clk);
        X = 32'd100;
        Y = 32'd7;
        start = 1'b1;
        sb.push_back('{z: 64'h00000002_0000000E, dz: 1'b0});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 4) begin
                start = 1'b1;
                X = 32'd1;
                Y = 32'd1;
            end
            if (k == 5) start = 1'b0;
            if (k == 9) begin
                X = 32'd3;
                Y = 32'd3;
            end
        end
        chk("stable_latency", 64'(k), 64'd33);
        repeat (40) @(negedge clk);
        chk("hold_Z", Z, 64'h00000002_0000000E);

        run(32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, DZ_LAT);
        repeat (40) @(negedge clk);
        chk("hold_dz", {63'd0, div_zero}, 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
